branch_predictor: RTL

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined datapath. It sits beside the PC in IF and predicts next-PC each cycle from the current fetch PC. ID trains it with the resolved branch/jump outcome once that outcome is known. This replaces the fixed predict-not-taken and flush-on-taken scheme, and keeps a saturating mispredict counter for performance measurement.

---
 rtl/branch_predictor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from registered state (no update bypass); updates
// from the resolving stage land on the next rising edge. A saturating counter
// tallies mispredicted control-flow instructions.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              flush_all,
    output logic              mispredict,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc_stat(input logic [STAT_W-1:0] c);
        return (c == STAT_MAX) ? c : c + STAT_W'(1);
    endfunction

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];
    logic [1:0]         cnt_d    [ENTRIES];
    logic [STAT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             upd_hit;
    logic [1:0]       unused_upd_pc_lsbs;

    // Instruction-aligned PCs: the two low bits take no part in index or tag.
    assign lk_idx             = lookup_pc[IDX_W+1:2];
    assign lk_tag             = lookup_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx            = upd_pc[IDX_W+1:2];
    assign upd_tag            = upd_pc[ADDR_W-1:IDX_W+2];
    assign unused_upd_pc_lsbs = upd_pc[1:0];
    assign upd_hit            = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Prediction path: pure function of lookup_pc and registered table state.
    always_comb begin
        pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken   = pred_hit && cnt_q[lk_idx][1];
        pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(4);
    end

    // Misprediction: wrong direction, or right "taken" direction to a wrong target.
    always_comb begin
        mispredict = upd_valid &&
                     ((upd_pred_taken != upd_taken) ||
                      (upd_taken && (upd_pred_target != upd_target)));
        mispred_cnt_d = mispredict ? sat_inc_stat(mispred_cnt_q) : mispred_cnt_q;
    end

    assign mispred_cnt = mispred_cnt_q;

    // Table next-state: flush wins over a concurrent update, which is dropped.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (flush_all) begin
            valid_d = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_d[i] = 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                cnt_d[upd_idx] = upd_taken ? sat_inc2(cnt_q[upd_idx])
                                           : sat_dec2(cnt_q[upd_idx]);
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                // Direct-mapped: a different-tag occupant is simply replaced.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                cnt_d[upd_idx]    = 2'b10;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else begin
            valid_q       <= valid_d;
            mispred_cnt_q <= mispred_cnt_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

endmodule
